// File: rtl/uart_link_sched.sv
// Round-robin sequencer sharing one UART transmitter between two byte requesters,
// plus receive-side arming and a valid/ack holding register with overrun detection.
module uart_link_sched #(
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 1023,
   parameter int CNT_W        = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt1,
   output logic       uart_init_tx,
   output logic [7:0] uart_data_in,
   input  logic       uart_tx_busy,
   input  logic       rx_en,
   output logic       uart_init_rx,
   input  logic       uart_done,
   input  logic [7:0] uart_data_out,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   input  logic       err_clr,
   output logic       tx_timeout,
   output logic       rx_overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_e;

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
   localparam state_e           AFTER_TX = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             ptr_q, ptr_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             init_tx_q, init_tx_d;
   logic [7:0]       data_in_q, data_in_d;
   logic             init_rx_q, init_rx_d;
   logic             done_q;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             tx_timeout_q, tx_timeout_d;
   logic             rx_overrun_q, rx_overrun_d;
   logic             win, to_set, ovr_set, done_rise;

   // ptr_q holds the last winner; on a tie the other requester goes next
   assign win       = (req0 & req1) ? ~ptr_q : req1;
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign done_rise = uart_done & ~done_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      init_tx_d = init_tx_q;
      data_in_d = data_in_q;
      to_set    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               data_in_d = win ? data1 : data0;
               ptr_d     = win;
               gnt0_d    = ~win;
               gnt1_d    = win;
               init_tx_d = 1'b1;
               state_d   = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // init_tx stays up until the core accepts, even if it is busy receiving
            if (uart_tx_busy) begin
               init_tx_d = 1'b0;
               state_d   = S_WAIT_DONE;
            end else if (cnt_q == TO_LAST) begin
               to_set    = 1'b1;
               init_tx_d = 1'b0;
               cnt_d     = '0;
               state_d   = AFTER_TX;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WAIT_DONE: begin
            if (!uart_tx_busy) begin
               cnt_d   = '0;
               state_d = AFTER_TX;
            end
         end
         S_GAP: begin
            cnt_d = cnt_inc;
            if (cnt_q == GAP_LAST) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      init_rx_d  = rx_en & (state_q == S_IDLE) & ~req0 & ~req1;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      ovr_set    = 1'b0;
      if (done_rise) begin
         if (!rx_valid_q || rx_ack) begin
            rx_data_d  = uart_data_out;
            rx_valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (rx_ack) begin
         rx_valid_d = 1'b0;
      end
      tx_timeout_d = to_set  | (tx_timeout_q & ~err_clr);
      rx_overrun_d = ovr_set | (rx_overrun_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         ptr_q        <= 1'b1;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         init_tx_q    <= 1'b0;
         data_in_q    <= '0;
         init_rx_q    <= 1'b0;
         done_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         tx_timeout_q <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         init_tx_q    <= init_tx_d;
         data_in_q    <= data_in_d;
         init_rx_q    <= init_rx_d;
         done_q       <= uart_done;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         tx_timeout_q <= tx_timeout_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign gnt0         = gnt0_q;
   assign gnt1         = gnt1_q;
   assign uart_init_tx = init_tx_q;
   assign uart_data_in = data_in_q;
   assign uart_init_rx = init_rx_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign tx_timeout   = tx_timeout_q;
   assign rx_overrun   = rx_overrun_q;

endmodule
